// File: rtl/button_event_ctrl.sv
// Button gesture classifier: SHORT / DOUBLE / LONG (/ REPEAT) events behind a valid/ready handshake.
// Define BUTTON_EVT_REPEAT_EN to enable auto-repeat events while the button stays held.
module button_event_ctrl #(
   parameter int TICK_DIV  = 100000,
   parameter int LONG_MS   = 800,
   parameter int DCLICK_MS = 250,
   parameter int REPEAT_MS = 100
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       button_in,
   output logic       event_valid,
   input  logic       event_ready,
   output logic [1:0] event_code,
   output logic       overflow,
   input  logic       overflow_clr,
   output logic [2:0] state
);
   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [11:0]   LONG_C     = 12'(LONG_MS);
   localparam logic [11:0]   DCLICK_C   = 12'(DCLICK_MS);
   localparam logic [11:0]   REPEAT_C   = 12'(REPEAT_MS);
   localparam logic [11:0]   MS_MAX     = 12'hFFF;

`ifdef BUTTON_EVT_REPEAT_EN
   localparam bit REPEAT_EN = 1'b1;
`else
   localparam bit REPEAT_EN = 1'b0;
`endif

   localparam logic [1:0] EV_SHORT  = 2'd0;
   localparam logic [1:0] EV_DOUBLE = 2'd1;
   localparam logic [1:0] EV_LONG   = 2'd2;
   localparam logic [1:0] EV_REPEAT = 2'd3;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      PRESSED = 3'd1,
      WAIT2   = 3'd2,
      SECOND  = 3'd3,
      HELD    = 3'd4
   } fsm_t;

   fsm_t          cur_st;
   fsm_t          nxt_st;
   logic [PW-1:0] presc;
   logic          tick;
   logic [11:0]   ms_cnt;
   logic          raise;
   logic [1:0]    raise_code;
   logic          ms_restart;
   logic          drop;
   logic          load;

   assign tick  = (presc == PRESC_LAST);
   assign state = cur_st;

   // A new event is lost only when the pending one is not being accepted this cycle.
   assign drop = raise && event_valid && !event_ready;
   assign load = raise && !drop;

   always_comb begin
      nxt_st     = cur_st;
      raise      = 1'b0;
      raise_code = EV_SHORT;
      ms_restart = 1'b0;
      case (cur_st)
         IDLE: begin
            if (button_in) nxt_st = PRESSED;
         end
         PRESSED: begin
            if (!button_in) begin
               nxt_st = WAIT2;
            end else if (ms_cnt == LONG_C) begin
               raise      = 1'b1;
               raise_code = EV_LONG;
               nxt_st     = HELD;
            end
         end
         WAIT2: begin
            if (button_in) begin
               nxt_st = SECOND;
            end else if (ms_cnt == DCLICK_C) begin
               raise      = 1'b1;
               raise_code = EV_SHORT;
               nxt_st     = IDLE;
            end
         end
         SECOND: begin
            if (!button_in) begin
               raise      = 1'b1;
               raise_code = EV_DOUBLE;
               nxt_st     = IDLE;
            end
         end
         HELD: begin
            if (!button_in) begin
               nxt_st = IDLE;
            end else if (REPEAT_EN && ms_cnt == REPEAT_C) begin
               raise      = 1'b1;
               raise_code = EV_REPEAT;
               ms_restart = 1'b1;
            end
         end
         default: nxt_st = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc       <= '0;
         ms_cnt      <= '0;
         cur_st      <= IDLE;
         event_valid <= 1'b0;
         event_code  <= EV_SHORT;
         overflow    <= 1'b0;
      end else begin
         presc  <= tick ? '0 : presc + PW'(1);
         cur_st <= nxt_st;
         // Every state change restarts the ms timer, dropping any tick on that edge.
         if (nxt_st != cur_st || ms_restart)
            ms_cnt <= '0;
         else if (tick && ms_cnt != MS_MAX)
            ms_cnt <= ms_cnt + 12'd1;
         if (load) begin
            event_valid <= 1'b1;
            event_code  <= raise_code;
         end else if (event_valid && event_ready) begin
            event_valid <= 1'b0;
         end
         if (drop)
            overflow <= 1'b1;
         else if (overflow_clr)
            overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Self-checking bench for button_event_ctrl: directed gesture scenarios plus randomized
// button/ready/clear traffic compared cycle by cycle against a timestamp-based reference model.
module tb_button_event_ctrl;
   localparam int TD = 4;
   localparam int LM = 10;
   localparam int DM = 5;
   localparam int RM = 3;
   localparam int P_IDLE = 0, P_PRESSED = 1, P_WAIT2 = 2, P_SECOND = 3, P_HELD = 4;
`ifdef BUTTON_EVT_REPEAT_EN
   localparam bit REPEAT_ON = 1'b1;
`else
   localparam bit REPEAT_ON = 1'b0;
`endif

   logic       clk;
   logic       rst;
   logic       button_in;
   logic       event_valid;
   logic       event_ready;
   logic [1:0] event_code;
   logic       overflow;
   logic       overflow_clr;
   logic [2:0] state;

   int checks = 0;
   int errors = 0;

   // Reference model: phase plus the edge index at which the phase began; elapsed ms is
   // the number of tick edges (every TD-th edge after reset) since that entry edge.
   int         k;
   int         m_phase;
   int         m_entry;
   logic       m_v;
   logic       m_ovf;
   logic [1:0] m_code;
   int         first_k;
   logic [1:0] acc_log[$];

   button_event_ctrl #(
      .TICK_DIV (TD),
      .LONG_MS  (LM),
      .DCLICK_MS(DM),
      .REPEAT_MS(RM)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .button_in   (button_in),
      .event_valid (event_valid),
      .event_ready (event_ready),
      .event_code  (event_code),
      .overflow    (overflow),
      .overflow_clr(overflow_clr),
      .state       (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      k       = 0;
      m_phase = P_IDLE;
      m_entry = 0;
      m_v     = 1'b0;
      m_ovf   = 1'b0;
      m_code  = 2'd0;
      first_k = -1;
      acc_log.delete();
   endtask

   task automatic apply_reset(input logic b);
      button_in    = b;
      event_ready  = 1'b0;
      overflow_clr = 1'b0;
      rst          = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
   endtask

   // One clock: drive inputs, advance the model, sample after the edge.
   task automatic step(input logic b, input logic r, input logic c);
      int         ms;
      bit         ev;
      bit         rs;
      bit         drop;
      int         np;
      logic [1:0] ec;
      @(negedge clk);
      button_in    = b;
      event_ready  = r;
      overflow_clr = c;
      if (event_valid === 1'b1 && event_ready === 1'b1) acc_log.push_back(event_code);
      k++;
      ms = (k - 1) / TD - m_entry / TD;
      if (ms > 4095) ms = 4095;
      ev = 1'b0;
      rs = 1'b0;
      ec = 2'd0;
      np = m_phase;
      case (m_phase)
         P_IDLE:    if (b) np = P_PRESSED;
         P_PRESSED: if (!b) np = P_WAIT2;
                    else if (ms == LM) begin ev = 1'b1; ec = 2'd2; np = P_HELD; end
         P_WAIT2:   if (b) np = P_SECOND;
                    else if (ms == DM) begin ev = 1'b1; ec = 2'd0; np = P_IDLE; end
         P_SECOND:  if (!b) begin ev = 1'b1; ec = 2'd1; np = P_IDLE; end
         default:   if (!b) np = P_IDLE;
                    else if (REPEAT_ON && ms == RM) begin ev = 1'b1; ec = 2'd3; rs = 1'b1; end
      endcase
      if (np != m_phase || rs) m_entry = k;
      m_phase = np;
      drop = ev && m_v && !r;
      if (ev && !drop) begin
         m_v    = 1'b1;
         m_code = ec;
      end else if (m_v && r) begin
         m_v = 1'b0;
      end
      if (drop) m_ovf = 1'b1;
      else if (c) m_ovf = 1'b0;
      @(posedge clk);
      #1;
      if (event_valid === 1'b1 && first_k < 0) first_k = k;
   endtask

   task automatic test_reset();
      rst = 1'b1; button_in = 1'b0; event_ready = 1'b0; overflow_clr = 1'b0;
      @(posedge clk);
      #1;
      checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
      checks++; if (event_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", event_valid); end
      checks++; if (event_code !== 2'd0) begin errors++; $display("FAIL reset_code: got %0d expected 0", event_code); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
      rst = 1'b0;
      model_reset();
      repeat (3) step(1'b0, 1'b1, 1'b0);
      checks++; if (state !== 3'd0 || event_valid !== 1'b0) begin errors++; $display("FAIL idle_quiet: state %0d valid %b expected 0 0", state, event_valid); end
      step(1'b1, 1'b1, 1'b0);
      checks++; if (state !== 3'd1) begin errors++; $display("FAIL enter_pressed: got %0d expected 1", state); end
      step(1'b0, 1'b1, 1'b0);
      checks++; if (state !== 3'd2) begin errors++; $display("FAIL enter_wait2: got %0d expected 2", state); end
   endtask

   task automatic test_short();
      apply_reset(1'b0);
      repeat (12) step(1'b1, 1'b1, 1'b0);
      repeat (40) step(1'b0, 1'b1, 1'b0);
      checks++; if (first_k !== 33) begin errors++; $display("FAIL short_timing: valid rose at edge %0d expected 33", first_k); end
      checks++; if (acc_log.size() !== 1) begin errors++; $display("FAIL short_count: got %0d events expected 1", acc_log.size()); end
      else begin
         checks++; if (acc_log[0] !== 2'd0) begin errors++; $display("FAIL short_code: got %0d expected 0", acc_log[0]); end
      end
      checks++; if (state !== 3'd0) begin errors++; $display("FAIL short_end_state: got %0d expected 0", state); end
   endtask

   task automatic test_double();
      apply_reset(1'b0);
      repeat (8) step(1'b1, 1'b1, 1'b0);
      repeat (8) step(1'b0, 1'b1, 1'b0);
      repeat (8) step(1'b1, 1'b1, 1'b0);
      repeat (40) step(1'b0, 1'b1, 1'b0);
      checks++; if (first_k !== 25) begin errors++; $display("FAIL double_timing: valid rose at edge %0d expected 25", first_k); end
      checks++; if (acc_log.size() !== 1) begin errors++; $display("FAIL double_count: got %0d events expected 1", acc_log.size()); end
      else begin
         checks++; if (acc_log[0] !== 2'd1) begin errors++; $display("FAIL double_code: got %0d expected 1", acc_log[0]); end
      end
   endtask

   task automatic test_long();
      logic [1:0] exp[$];
      exp.push_back(2'd2);
`ifdef BUTTON_EVT_REPEAT_EN
      repeat (4) exp.push_back(2'd3);
`endif
      apply_reset(1'b0);
      repeat (100) step(1'b1, 1'b1, 1'b0);
      repeat (20) step(1'b0, 1'b1, 1'b0);
      checks++; if (first_k !== 41) begin errors++; $display("FAIL long_timing: valid rose at edge %0d expected 41", first_k); end
      checks++; if (acc_log.size() !== exp.size()) begin errors++; $display("FAIL long_count: got %0d events expected %0d", acc_log.size(), exp.size()); end
      else begin
         for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (acc_log[i] !== exp[i]) begin errors++; $display("FAIL long_code[%0d]: got %0d expected %0d", i, acc_log[i], exp[i]); end
         end
      end
      checks++; if (state !== 3'd0) begin errors++; $display("FAIL long_end_state: got %0d expected 0", state); end
   endtask

   task automatic test_overflow();
      int ovf_cycles;
      apply_reset(1'b0);
      repeat (4) step(1'b1, 1'b0, 1'b0);
      repeat (26) step(1'b0, 1'b0, 1'b0);
      checks++; if (event_valid !== 1'b1 || event_code !== 2'd0 || overflow !== 1'b0) begin
         errors++; $display("FAIL ovf_first_pending: valid %b code %0d ovf %b expected 1 0 0", event_valid, event_code, overflow); end
      // Second SHORT is dropped while overflow_clr is held: set wins for one cycle, then clears.
      ovf_cycles = 0;
      repeat (4) step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 26; i++) begin
         step(1'b0, 1'b0, 1'b1);
         if (overflow === 1'b1) ovf_cycles++;
         checks++; if (overflow !== m_ovf || event_valid !== m_v) begin
            errors++; $display("FAIL ovf_clr_race: ovf %b valid %b expected %b %b", overflow, event_valid, m_ovf, m_v); end
      end
      checks++; if (ovf_cycles !== 1) begin errors++; $display("FAIL ovf_set_priority: overflow high %0d cycles expected 1", ovf_cycles); end
      repeat (4) step(1'b1, 1'b0, 1'b0);
      repeat (26) step(1'b0, 1'b0, 1'b0);
      checks++; if (overflow !== 1'b1 || event_valid !== 1'b1 || event_code !== 2'd0) begin
         errors++; $display("FAIL ovf_sticky: ovf %b valid %b code %0d expected 1 1 0", overflow, event_valid, event_code); end
      step(1'b0, 1'b0, 1'b1);
      checks++; if (overflow !== 1'b0 || event_valid !== 1'b1) begin
         errors++; $display("FAIL ovf_clear: ovf %b valid %b expected 0 1", overflow, event_valid); end
   endtask

   task automatic test_reset_mid_press();
      repeat (30) step(1'b1, 1'b0, 1'b0);
      checks++; if (state !== 3'd1 || event_valid !== 1'b1) begin
         errors++; $display("FAIL mid_press_pre: state %0d valid %b expected 1 1", state, event_valid); end
      #2 rst = 1'b1;
      #1;
      checks++; if (state !== 3'd0 || event_valid !== 1'b0 || event_code !== 2'd0 || overflow !== 1'b0) begin
         errors++; $display("FAIL async_reset: state %0d valid %b code %0d ovf %b expected 0 0 0 0", state, event_valid, event_code, overflow); end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      for (int i = 1; i <= 45; i++) begin
         step(1'b1, 1'b1, 1'b0);
         if (i == 1) begin
            checks++; if (state !== 3'd1) begin errors++; $display("FAIL reset_repress: got %0d expected 1", state); end
         end
      end
      checks++; if (first_k !== 41) begin errors++; $display("FAIL reset_long_timing: valid rose at edge %0d expected 41", first_k); end
      checks++; if (acc_log.size() !== 1) begin errors++; $display("FAIL reset_long_count: got %0d events expected 1", acc_log.size()); end
      else begin
         checks++; if (acc_log[0] !== 2'd2) begin errors++; $display("FAIL reset_long_code: got %0d expected 2", acc_log[0]); end
      end
   endtask

   task automatic test_back_to_back();
      apply_reset(1'b0);
      repeat (4) step(1'b1, 1'b0, 1'b0);
      repeat (26) step(1'b0, 1'b0, 1'b0);
      repeat (3) step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      // DOUBLE raised on the same edge the pending SHORT is accepted.
      step(1'b0, 1'b1, 1'b0);
      checks++; if (event_valid !== 1'b1 || event_code !== 2'd1 || overflow !== 1'b0) begin
         errors++; $display("FAIL b2b_load: valid %b code %0d ovf %b expected 1 1 0", event_valid, event_code, overflow); end
      step(1'b0, 1'b1, 1'b0);
      checks++; if (event_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: valid %b expected 0", event_valid); end
      checks++; if (acc_log.size() !== 2) begin errors++; $display("FAIL b2b_count: got %0d events expected 2", acc_log.size()); end
      else begin
         checks++; if (acc_log[0] !== 2'd0 || acc_log[1] !== 2'd1) begin
            errors++; $display("FAIL b2b_order: got %0d,%0d expected 0,1", acc_log[0], acc_log[1]); end
      end
   endtask

   task automatic test_random();
      int   n;
      int   len;
      logic b;
      apply_reset(1'b0);
      n = 0;
      b = 1'b0;
      while (n < 3000) begin
         len = ($urandom_range(0, 4) == 0) ? $urandom_range(30, 70) : $urandom_range(1, 24);
         for (int i = 0; i < len; i++) begin
            step(b, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
            n++;
            checks++; if (state !== 3'(m_phase)) begin errors++; $display("FAIL rand_state @%0d: got %0d expected %0d", k, state, m_phase); end
            checks++; if (event_valid !== m_v) begin errors++; $display("FAIL rand_valid @%0d: got %b expected %b", k, event_valid, m_v); end
            checks++; if (event_code !== m_code) begin errors++; $display("FAIL rand_code @%0d: got %0d expected %0d", k, event_code, m_code); end
            checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rand_overflow @%0d: got %b expected %b", k, overflow, m_ovf); end
         end
         b = !b;
      end
   endtask

   initial begin
      test_reset();
      test_short();
      test_double();
      test_long();
      test_overflow();
      test_reset_mid_press();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/button_event_ctrl.md
BUTTON_EVENT_CTRL -- requirements
Module: button_event_ctrl

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 100000, meaning clk cycles per 1 ms tick (legal range 2..2^20).
REQ-002 The block SHALL have parameter LONG_MS, default 800, meaning hold time in ms that classifies a press as long (legal range 1..4095).
REQ-003 The block SHALL have parameter DCLICK_MS, default 250, meaning the max release gap in ms before a second press (legal range 1..4095).
REQ-004 The block SHALL have parameter REPEAT_MS, default 100, meaning the auto-repeat period in ms (legal range 1..4095).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port button_in, input, 1 bit: debounced, clk-synchronous button level, 1 = pressed.
REQ-008 The block SHALL have port event_valid, output, 1 bit: an event is pending.
REQ-009 The block SHALL have port event_ready, input, 1 bit: the consumer accepts the event.
REQ-010 The block SHALL have port event_code, output, 2 bits: 0 SHORT, 1 DOUBLE, 2 LONG, 3 REPEAT.
REQ-011 The block SHALL have port overflow, output, 1 bit: sticky flag meaning an event was dropped.
REQ-012 The block SHALL have port overflow_clr, input, 1 bit: clears overflow.
REQ-013 The block SHALL have port state, output, 3 bits: current FSM state encoding, for debug.

Function
REQ-014 The prescaler SHALL count 0..TICK_DIV-1 and wrap, asserting tick for one clk cycle when it wraps.
REQ-015 A 12-bit ms_cnt SHALL increment on each tick, saturate at 4095, and clear to 0 on every FSM state change.
REQ-016 FSM states SHALL be IDLE=0, PRESSED=1, WAIT2=2, SECOND=3, HELD=4.
REQ-017 IDLE SHALL go to PRESSED when button_in=1.
REQ-018 PRESSED with button_in=0 SHALL go to WAIT2; PRESSED with ms_cnt==LONG_MS SHALL raise LONG and go to HELD; release takes priority if both occur in the same cycle.
REQ-019 WAIT2 with button_in=1 SHALL go to SECOND; WAIT2 with ms_cnt==DCLICK_MS SHALL raise SHORT and go to IDLE; the press takes priority if both occur in the same cycle.
REQ-020 SECOND with button_in=0 SHALL raise DOUBLE and go to IDLE, regardless of hold duration.
REQ-021 HELD with button_in=0 SHALL go to IDLE with no event.
REQ-022 Event registration SHALL have 1-clk latency: event_valid and event_code update on the clk edge after the triggering condition.
REQ-023 event_valid SHALL remain high and event_code SHALL remain stable until a cycle with event_valid=1 and event_ready=1, after which event_valid clears.
REQ-024 If a new event is raised while event_valid=1 and event_ready=0, the new event SHALL be dropped and overflow set; the pending event SHALL be unchanged.
REQ-025 If a new event is raised in the same cycle as an accept (event_valid=1, event_ready=1), the new event SHALL be loaded and event_valid SHALL stay 1 with no overflow.
REQ-026 overflow_clr=1 SHALL clear overflow on the next edge; a simultaneous drop SHALL take priority and leave overflow=1.
REQ-027 The prescaler SHALL free-run independently of the FSM, so the first ms of any state may be short by up to TICK_DIV-1 cycles.

Reset
REQ-028 While rst=1, all of the following SHALL hold asynchronously: state=IDLE, ms_cnt=0, prescaler=0, event_valid=0, event_code=0, overflow=0.
REQ-029 Reset mid-press SHALL discard any classification in progress; after rst falls with button_in=1, the FSM SHALL enter PRESSED on the next edge and time the press from there.

Configuration
REQ-030 The macro BUTTON_EVT_REPEAT_EN SHALL control auto-repeat as follows:
- when defined, HELD SHALL raise REPEAT each time ms_cnt reaches REPEAT_MS, clearing ms_cnt to 0 on that cycle;
- when undefined, HELD SHALL raise no events and event_code 3 SHALL never appear.

Verification
(Parameters for all scenarios: TICK_DIV=4, LONG_MS=10, DCLICK_MS=5, REPEAT_MS=3.)
REQ-031 Scenario: press 12 clk, release, idle 40 clk -> exactly one SHORT (code 0), with event_valid rising 1 clk after ms_cnt hits 5 in WAIT2.
REQ-032 Scenario: press 8 clk, release 8 clk, press 8 clk, release -> one DOUBLE (code 1) 1 clk after the second release, and no SHORT.
REQ-033 Scenario: hold 60 clk with the macro undefined -> one LONG (code 2) around clk 40-44; release -> no further event.
REQ-034 Scenario: hold 100 clk with BUTTON_EVT_REPEAT_EN defined -> LONG followed by a REPEAT every 12 clk (±1 tick) while event_ready=1.
REQ-035 Scenario: event_ready held 0, then two SHORT presses -> first SHORT held stable, overflow=1; then pulse overflow_clr -> overflow=0 and the event still pending.
REQ-036 Scenario: assert rst during PRESSED at clk 30 of a hold -> outputs 0 and state=0 immediately; after release of rst with the button still held, LONG SHALL arrive about 40 clk later.
